pulso_tx: RTL and testbench

Output-side event transmitter. It converts single-cycle internal event strobes from the CPU peripheral into clean, glitch-free, registered pulses on an external line, with a guaranteed minimum high time and a minimum low gap. This lets a remote receiver, sampling through a multi-flop synchronizer and debounce filter, capture every event. Bursts are queued in a saturating pending counter so events are not lost while a pulse is in flight.

---
 rtl/pulso_tx_pkg.sv | 22 ++
 rtl/pulso_tx_fase.sv | 49 ++++
 rtl/pulso_tx.sv | 171 +++++++++++++++++
 tb/tb_pulso_tx.sv | 199 +++++++++++++++++++
 4 files changed

// File: rtl/pulso_tx_pkg.sv
// -----------------------------------------------------------------------------
// pulso_tx_pkg
// Shared definitions for the pulso_tx event transmitter.
//   estado_t : transmitter FSM states (IDLE, HIGH, LOW)
//   fase_w() : width of the phase timer so it can hold max(HIGH_CYC, LOW_CYC)
// -----------------------------------------------------------------------------
package pulso_tx_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        HIGH = 2'd1,
        LOW  = 2'd2
    } estado_t;

    // Timer width: enough bits to count up to the longer of the two phases.
    function automatic int fase_w(input int high_cyc, input int low_cyc);
        int m;
        m = (high_cyc > low_cyc) ? high_cyc : low_cyc;
        return $clog2(m + 1);
    endfunction

endpackage

// File: rtl/pulso_tx_fase.sv
// -----------------------------------------------------------------------------
// contador_fase
// Parameterized phase up-counter with synchronous clear and a done flag.
// The counter restarts from zero whenever clr is high and otherwise counts up
// one per cycle, holding at all-ones so it never wraps while parked in IDLE.
// Ports:
//   clk    : system clock, posedge
//   rst    : synchronous active-low reset
//   clr    : restart the count at zero on the next edge
//   limite : terminal count for the current phase
//   done   : high while the count equals limite (last cycle of the phase)
// -----------------------------------------------------------------------------
module contador_fase #(
    parameter int W = 3
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         clr,
    input  logic [W-1:0] limite,
    output logic         done
);

    logic [W-1:0] cnt_d;
    logic [W-1:0] cnt_q;

    // Next-count logic: clear, count up, or hold at the top.
    always_comb begin
        cnt_d = cnt_q;
        if (clr) begin
            cnt_d = {W{1'b0}};
        end else if (cnt_q != {W{1'b1}}) begin
            cnt_d = cnt_q + W'(1'b1);
        end else begin
            cnt_d = cnt_q;
        end
    end

    // Count register with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!rst) begin
            cnt_q <= {W{1'b0}};
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign done = (cnt_q == limite);

endmodule

// File: rtl/pulso_tx.sv
// -----------------------------------------------------------------------------
// pulso_tx
// Output-side event transmitter. Single-cycle event strobes are turned into
// registered pulses on 'out' that stay high for exactly HIGH_CYC cycles and
// are followed by at least LOW_CYC low cycles. Events arriving while a pulse
// is in flight are queued in a saturating pending counter.
// Ports:
//   clk      : system clock, posedge
//   rst      : synchronous active-low reset (aborts any pulse in flight)
//   ev_in    : event strobe, one event per high cycle
//   en       : transmit enable; only gates the start of new pulses
//   clr_ovf  : clears the sticky overflow flag (a simultaneous set wins)
//   out      : registered pulse line, high exactly while the FSM is in HIGH
//   busy     : high while the FSM is in HIGH or LOW
//   pending  : number of queued, not-yet-transmitted events
//   overflow : sticky, an event was dropped because pending was full
// -----------------------------------------------------------------------------
module pulso_tx
    import pulso_tx_pkg::*;
#(
    parameter int HIGH_CYC = 4,
    parameter int LOW_CYC  = 4,
    parameter int CNT_W    = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             ev_in,
    input  logic             en,
    input  logic             clr_ovf,
    output logic             out,
    output logic             busy,
    output logic [CNT_W-1:0] pending,
    output logic             overflow
);

    localparam int               TW       = fase_w(HIGH_CYC, LOW_CYC);
    localparam logic [TW-1:0]    LIM_HIGH = TW'(HIGH_CYC - 1);
    localparam logic [TW-1:0]    LIM_LOW  = TW'(LOW_CYC - 1);
    localparam logic [CNT_W-1:0] PEND_MAX = {CNT_W{1'b1}};

    estado_t          state_d;
    estado_t          state_q;
    logic [CNT_W-1:0] pending_d;
    logic [CNT_W-1:0] pending_q;
    logic             overflow_d;
    logic             overflow_q;
    logic             out_d;
    logic             out_q;
    logic             busy_d;
    logic             busy_q;

    logic             start_s;
    logic             consume_s;
    logic             inc_s;
    logic             dec_s;
    logic             ovf_set_s;
    logic             fase_clr_s;
    logic [TW-1:0]    fase_lim_s;
    logic             fase_done_s;

    // Phase timer: restarted on every state change, terminal count depends on phase.
    contador_fase #(
        .W (TW)
    ) u_fase (
        .clk    (clk),
        .rst    (rst),
        .clr    (fase_clr_s),
        .limite (fase_lim_s),
        .done   (fase_done_s)
    );

    // Terminal count of the phase currently running.
    always_comb begin
        fase_lim_s = LIM_LOW;
        if (state_q == HIGH) begin
            fase_lim_s = LIM_HIGH;
        end else begin
            fase_lim_s = LIM_LOW;
        end
    end

    // Next-state logic; pulses are only started from IDLE or at the end of LOW.
    always_comb begin
        start_s = en && (ev_in || (pending_q != {CNT_W{1'b0}}));
        state_d = state_q;
        case (state_q)
            IDLE: begin
                if (start_s) begin
                    state_d = HIGH;
                end else begin
                    state_d = IDLE;
                end
            end
            HIGH: begin
                if (fase_done_s) begin
                    state_d = LOW;
                end else begin
                    state_d = HIGH;
                end
            end
            LOW: begin
                if (fase_done_s) begin
                    state_d = start_s ? HIGH : IDLE;
                end else begin
                    state_d = LOW;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
        fase_clr_s = (state_d != state_q);
        out_d      = (state_d == HIGH);
        busy_d     = (state_d != IDLE);
    end

    // Pending counter and overflow flag.
    // A HIGH entry consumes one event; with nothing queued, the event arriving
    // in that same cycle is the one consumed, so it is never counted.
    always_comb begin
        consume_s  = (state_d == HIGH) && (state_q != HIGH);
        dec_s      = consume_s && (pending_q != {CNT_W{1'b0}});
        inc_s      = ev_in && !(consume_s && (pending_q == {CNT_W{1'b0}}));
        ovf_set_s  = 1'b0;
        pending_d  = pending_q;
        if (inc_s && !dec_s) begin
            if (pending_q == PEND_MAX) begin
                ovf_set_s = 1'b1;
                pending_d = pending_q;
            end else begin
                pending_d = pending_q + CNT_W'(1'b1);
            end
        end else if (dec_s && !inc_s) begin
            pending_d = pending_q - CNT_W'(1'b1);
        end else begin
            pending_d = pending_q;
        end

        // Set has priority over clear.
        if (ovf_set_s) begin
            overflow_d = 1'b1;
        end else if (clr_ovf) begin
            overflow_d = 1'b0;
        end else begin
            overflow_d = overflow_q;
        end
    end

    // State, counter and registered outputs with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q    <= IDLE;
            pending_q  <= {CNT_W{1'b0}};
            overflow_q <= 1'b0;
            out_q      <= 1'b0;
            busy_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            pending_q  <= pending_d;
            overflow_q <= overflow_d;
            out_q      <= out_d;
            busy_q     <= busy_d;
        end
    end

    assign out      = out_q;
    assign busy     = busy_q;
    assign pending  = pending_q;
    assign overflow = overflow_q;

endmodule

// File: tb/tb_pulso_tx.sv
// -----------------------------------------------------------------------------
// tb_pulso_tx
// Directed bench for pulso_tx. Instance dut uses the default parameters;
// instance dut_sat uses CNT_W=2 for the saturation scenario. Inputs change
// 1 time unit after a rising edge, and outputs are sampled at that same point,
// so each sample reflects the edge that has just occurred.
// -----------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_pulso_tx;

    logic       clk;
    logic       rst;
    logic       ev_in;
    logic       en;
    logic       clr_ovf;
    logic       out;
    logic       busy;
    logic [3:0] pending;
    logic       overflow;

    logic       ev2;
    logic       en2;
    logic       clr2;
    logic       out2;
    logic       busy2;
    logic [1:0] pending2;
    logic       overflow2;

    int n_tests;
    int n_fail;

    logic [31:0] tr_out;
    logic [31:0] tr_busy;
    logic [3:0]  pend_obs [0:31];

    pulso_tx dut (
        .clk      (clk),
        .rst      (rst),
        .ev_in    (ev_in),
        .en       (en),
        .clr_ovf  (clr_ovf),
        .out      (out),
        .busy     (busy),
        .pending  (pending),
        .overflow (overflow)
    );

    pulso_tx #(
        .HIGH_CYC (4),
        .LOW_CYC  (4),
        .CNT_W    (2)
    ) dut_sat (
        .clk      (clk),
        .rst      (rst),
        .ev_in    (ev2),
        .en       (en2),
        .clr_ovf  (clr2),
        .out      (out2),
        .busy     (busy2),
        .pending  (pending2),
        .overflow (overflow2)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Run n cycles, recording out/busy/pending after each edge; ev_in is high
    // for the first n_ev input cycles (counting from the current one).
    task automatic record(input int n, input int n_ev);
        tr_out  = 32'd0;
        tr_busy = 32'd0;
        for (int i = 0; i < n; i++) begin
            ev_in = (i < n_ev) ? 1'b1 : 1'b0;
            tick();
            tr_out[i]   = out;
            tr_busy[i]  = busy;
            pend_obs[i] = pending;
        end
        ev_in = 1'b0;
    endtask

    initial begin
        n_tests = 0;
        n_fail  = 0;
        rst     = 1'b0;
        ev_in   = 1'b0;
        en      = 1'b1;
        clr_ovf = 1'b0;
        ev2     = 1'b0;
        en2     = 1'b0;
        clr2    = 1'b0;

        // 1. Reset held low, then released with no events.
        for (int i = 0; i < 3; i++) begin
            tick();
            check_eq("reset_hold", {28'd0, out, busy, pending != 4'd0, overflow}, 32'd0);
        end
        rst = 1'b1;
        for (int i = 0; i < 4; i++) begin
            tick();
            check_eq("idle_after_reset", {26'd0, out, busy, pending}, 32'd0);
            check_eq("idle_ovf", {31'd0, overflow}, 32'd0);
        end

        // 2. Single event: 4 high, 4 low, then idle; pending never moves.
        record(10, 1);
        check_eq("single_out", tr_out & 32'h3FF, 32'h00F);
        check_eq("single_busy", tr_busy & 32'h3FF, 32'h0FF);
        for (int i = 0; i < 10; i++) begin
            check_eq("single_pend", {28'd0, pend_obs[i]}, 32'd0);
        end

        // 3. Burst of three events: three back-to-back pulses, no idle gap.
        record(30, 3);
        check_eq("burst_out", tr_out & 32'h3FFFFFFF, 32'h000F0F0F);
        check_eq("burst_busy", tr_busy & 32'h3FFFFFFF, 32'h00FFFFFF);
        check_eq("burst_pend0", {28'd0, pend_obs[0]}, 32'd0);
        check_eq("burst_pend1", {28'd0, pend_obs[1]}, 32'd1);
        check_eq("burst_pend2", {28'd0, pend_obs[2]}, 32'd2);
        check_eq("burst_pend7", {28'd0, pend_obs[7]}, 32'd2);
        check_eq("burst_pend8", {28'd0, pend_obs[8]}, 32'd1);
        check_eq("burst_pend16", {28'd0, pend_obs[16]}, 32'd0);
        check_eq("burst_ovf", {31'd0, overflow}, 32'd0);

        // 4. Saturation on the CNT_W=2 instance with en=0.
        for (int i = 0; i < 5; i++) begin
            ev2 = 1'b1;
            tick();
            if (i == 2) begin
                check_eq("sat_pend_at3", {30'd0, pending2}, 32'd3);
                check_eq("sat_ovf_at3", {31'd0, overflow2}, 32'd0);
            end
        end
        ev2 = 1'b0;
        check_eq("sat_pend", {30'd0, pending2}, 32'd3);
        check_eq("sat_ovf", {31'd0, overflow2}, 32'd1);
        check_eq("sat_out", {30'd0, out2, busy2}, 32'd0);
        ev2  = 1'b1;
        clr2 = 1'b1;
        tick();
        check_eq("sat_set_wins", {31'd0, overflow2}, 32'd1);
        ev2 = 1'b0;
        tick();
        check_eq("sat_clr", {31'd0, overflow2}, 32'd0);
        check_eq("sat_pend_kept", {30'd0, pending2}, 32'd3);
        clr2 = 1'b0;
        en2  = 1'b1;
        tick();
        check_eq("sat_drain_out", {31'd0, out2}, 32'd1);
        check_eq("sat_drain_pend", {30'd0, pending2}, 32'd2);
        en2 = 1'b0;

        // 5. Enable dropped mid-HIGH with two events queued.
        record(3, 3);
        check_eq("gate_pend_start", {28'd0, pending}, 32'd2);
        check_eq("gate_out_start", {31'd0, out}, 32'd1);
        en = 1'b0;
        record(15, 0);
        check_eq("gate_out", tr_out & 32'h7FFF, 32'h0001);
        check_eq("gate_busy", tr_busy & 32'h7FFF, 32'h001F);
        check_eq("gate_pend_held", {28'd0, pending}, 32'd2);
        en = 1'b1;
        record(20, 0);
        check_eq("gate_drain_out", tr_out & 32'hFFFFF, 32'h00F0F);
        check_eq("gate_drain_busy", tr_busy & 32'hFFFFF, 32'h0FFFF);
        check_eq("gate_drain_pend", {28'd0, pending}, 32'd0);

        // 6. Reset during the second HIGH cycle with one event queued.
        record(2, 2);
        check_eq("rst_pre_out", {31'd0, out}, 32'd1);
        check_eq("rst_pre_pend", {28'd0, pending}, 32'd1);
        rst = 1'b0;
        tick();
        check_eq("rst_mid_out", {31'd0, out}, 32'd0);
        check_eq("rst_mid_pend", {28'd0, pending}, 32'd0);
        check_eq("rst_mid_busy", {31'd0, busy}, 32'd0);
        rst = 1'b1;
        record(12, 0);
        check_eq("rst_no_residual_out", tr_out & 32'hFFF, 32'h000);
        check_eq("rst_no_residual_busy", tr_busy & 32'hFFF, 32'h000);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
